systolic_feeder: RTL and testbench
==================================

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameter N_CELLS, default 4: number of cells in the driven array; range 1..255.
REQ-002 Parameter W, default 32: data and coefficient width; the block SHALL be correct for W=32.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low; synchronous deassert is the integrator's responsibility.
REQ-005 start  input  1  one-cycle pulse that begins a job; SHALL be sampled only in IDLE.
REQ-006 stream_len  input  16  number of STREAM words in the job; SHALL be captured on the accepted start.
REQ-007 in_valid  input  1  upstream word valid.
REQ-008 in_ready  output  1  block accepts a word when in_valid and in_ready are both high.
REQ-009 in_data  input  W  operand word.
REQ-010 in_coef  input  W  coefficient paired with in_data.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse at job completion.
REQ-013 c_out  output  W  coefficient to the first cell's c_in.
REQ-014 x_out  output  W  data to the first cell's x_in.
REQ-015 s_out  output  1  select to the first cell's s_in; 1 marks a load word.

Function
REQ-016 FSM states: IDLE, LOAD, STREAM, FLUSH, DONE.
REQ-017 IDLE -> LOAD on start; start in any other state SHALL be ignored.
REQ-018 in_ready SHALL be 1 in LOAD and STREAM only; 0 in IDLE, FLUSH, DONE.
REQ-019 c_out, x_out and s_out SHALL be registered: an accepted word appears on them exactly 1 cycle after its handshake cycle.
REQ-020 LOAD: each accepted word SHALL be driven with s_out=1, x_out=in_data, c_out=in_coef.
REQ-021 LOAD SHALL accept exactly N_CELLS words, then go to STREAM, or to FLUSH if the captured stream_len is 0.
REQ-022 STREAM: each accepted word SHALL be driven with s_out=0, x_out=in_data, c_out=in_coef.
REQ-023 STREAM SHALL accept exactly stream_len words, then go to FLUSH.
REQ-024 Transitions SHALL occur on the cycle of the final handshake, so no extra word is accepted.
REQ-025 Bubble: in any cycle without a handshake, including LOAD/STREAM stalls, the next-cycle outputs SHALL be c_out=0, x_out=0, s_out=0.
REQ-026 FLUSH SHALL last exactly N_CELLS cycles with bubble outputs to drain the array, then go to DONE.
REQ-027 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-028 Word counters: the LOAD counter SHALL be at least 8 bits and the STREAM counter 16 bits; neither SHALL wrap during a legal job.
REQ-029 Coefficients and data SHALL pass unmodified; the block SHALL perform no arithmetic on the datapath.

Reset
REQ-030 While rst=0: state=IDLE, counters=0, c_out=0, x_out=0, s_out=0, in_ready=0, busy=0, done=0, asynchronously.
REQ-031 Reset asserted mid-job SHALL abandon the job with no done pulse; the first start after release SHALL begin a fresh job.
REQ-032 Words offered during reset SHALL NOT be accepted.

Verification
REQ-033 N_CELLS=4, stream_len=3, in_valid always 1 -> s_out=1 for 4 consecutive cycles, then s_out=0 with data for 3 cycles, 4 bubble cycles, done pulse; busy high for 12 cycles.
REQ-034 Stall: in_valid low for 2 cycles after LOAD word 2 -> two bubble cycles (all zero) between load words 2 and 3; exactly 4 load words are still accepted.
REQ-035 stream_len=0 -> LOAD followed directly by FLUSH; no s_out=0 data word; done follows 4 flush cycles.
REQ-036 start pulsed during STREAM -> ignored; the job length is unchanged and stream_len is not re-captured.
REQ-037 rst low during STREAM word 1 -> all outputs 0 immediately, no done pulse; a new start with stream_len=1 completes normally.
REQ-038 Data integrity: in_data=0x0000_0001..0x0000_0007 with in_coef=0xA5A5_0000+i -> identical values on x_out/c_out in order, each exactly 1 cycle after its handshake.

Source files
------------

// File: rtl/systolic_feeder_if.sv
// Upstream word channel into the systolic feeder: operand/coefficient pairs
// with a valid/ready handshake.
interface systolic_feeder_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [W-1:0] in_coef;

    modport master (output in_valid, output in_data, output in_coef, input in_ready);
    modport slave  (input in_valid, input in_data, input in_coef, output in_ready);
endinterface

// File: rtl/systolic_feeder.sv
// Feeds a linear systolic array: N_CELLS coefficient-load words (s_out=1),
// then stream_len data words (s_out=0), then N_CELLS bubble cycles to drain.
module systolic_feeder #(
    parameter int N_CELLS = 4,
    parameter int W       = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [15:0]         stream_len,
    systolic_feeder_if.slave    in_bus,
    output logic                busy,
    output logic                done,
    output logic [W-1:0]        c_out,
    output logic [W-1:0]        x_out,
    output logic                s_out
);
    localparam logic [7:0] LAST_CELL = 8'(N_CELLS - 1);

    typedef enum logic [2:0] {IDLE, LOAD, STREAM, FLUSH, DONE} state_t;

    state_t      state;
    logic [7:0]  cell_cnt;
    logic [15:0] word_cnt;
    logic [15:0] len_q;
    logic        ready_q;
    logic        hs;

    assign in_bus.in_ready = ready_q;
    assign hs = in_bus.in_valid && ready_q;

    // Outputs default to a bubble every cycle; only a handshake overrides them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cell_cnt <= '0;
            word_cnt <= '0;
            len_q    <= '0;
            ready_q  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            c_out    <= '0;
            x_out    <= '0;
            s_out    <= 1'b0;
        end else begin
            c_out <= '0;
            x_out <= '0;
            s_out <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q    <= stream_len;
                        cell_cnt <= '0;
                        word_cnt <= '0;
                        ready_q  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (hs) begin
                        c_out <= in_bus.in_coef;
                        x_out <= in_bus.in_data;
                        s_out <= 1'b1;
                        if (cell_cnt == LAST_CELL) begin
                            cell_cnt <= '0;
                            if (len_q == 16'd0) begin
                                ready_q <= 1'b0;
                                state   <= FLUSH;
                            end else begin
                                state   <= STREAM;
                            end
                        end else begin
                            cell_cnt <= cell_cnt + 8'd1;
                        end
                    end
                end
                STREAM: begin
                    if (hs) begin
                        c_out <= in_bus.in_coef;
                        x_out <= in_bus.in_data;
                        if (word_cnt == len_q - 16'd1) begin
                            word_cnt <= '0;
                            ready_q  <= 1'b0;
                            state    <= FLUSH;
                        end else begin
                            word_cnt <= word_cnt + 16'd1;
                        end
                    end
                end
                FLUSH: begin
                    // The load counter is reused to time the drain.
                    if (cell_cnt == LAST_CELL) begin
                        cell_cnt <= '0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cell_cnt <= cell_cnt + 8'd1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized scoreboard bench for systolic_feeder: a job-level model predicts
// every cycle's outputs, a negedge monitor pops and compares them.
module tb_systolic_feeder;
    localparam int N = 4;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [15:0]  stream_len = '0;
    logic         busy, done, s_out;
    logic [W-1:0] c_out, x_out;

    systolic_feeder_if #(.W(W)) bus ();

    systolic_feeder #(.N_CELLS(N), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stream_len (stream_len),
        .in_bus     (bus.slave),
        .busy       (busy),
        .done       (done),
        .c_out      (c_out),
        .x_out      (x_out),
        .s_out      (s_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         s;
        logic [W-1:0] x;
        logic [W-1:0] c;
        logic         rdy;
        logic         bsy;
        logic         dn;
    } obs_t;

    typedef struct {
        int   due;
        obs_t v;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always @(posedge clk) cyc++;

    function automatic obs_t mk(input logic s, input logic [W-1:0] x, input logic [W-1:0] c,
                                input logic r, input logic b, input logic d);
        return {s, x, c, r, b, d};
    endfunction

    task automatic check(input string name, input obs_t want);
        obs_t act;
        act = {s_out, x_out, c_out, bus.in_ready, busy, done};
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s cyc %0d: got s=%0b x=%h c=%h rdy=%0b busy=%0b done=%0b, want s=%0b x=%h c=%h rdy=%0b busy=%0b done=%0b",
                     name, cyc, act.s, act.x, act.c, act.rdy, act.bsy, act.dn,
                     want.s, want.x, want.c, want.rdy, want.bsy, want.dn);
        end
    endtask

    // Monitor: compares whatever expectation falls due on this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due < cyc) begin
            mon_e = sb.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL stale_expectation due %0d at cyc %0d", mon_e.due, cyc);
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            mon_e = sb.pop_front();
            check("scoreboard", mon_e.v);
        end
    end

    // One clock of stimulus; the expectation applies after the next rising edge.
    task automatic cycle(input logic st, input logic [15:0] len, input logic v,
                         input logic [W-1:0] d, input logic [W-1:0] cf, input obs_t e);
        start          = st;
        stream_len     = len;
        bus.in_valid   = v;
        bus.in_data    = d;
        bus.in_coef    = cf;
        sb.push_back('{cyc + 1, e});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 16'($urandom), 1'($urandom), $urandom, $urandom, mk(0, '0, '0, 0, 0, 0));
    endtask

    // Job model: N load words then len stream words (any valid word is taken),
    // then N bubble cycles with done on the last, then idle.
    // vmode: 0 always valid, 1 random gaps, 2 two-cycle stall after load word 2.
    task automatic run_job(input int len, input int vmode, input int dmode,
                           input bit poke_start, input int abort_at);
        logic [W-1:0] wd[$];
        logic [W-1:0] wc[$];
        int total, idx, stalls, guard;
        logic v, st;
        total = N + len;
        for (int i = 0; i < total; i++) begin
            if (dmode == 1) begin
                wd.push_back(W'(i + 1));
                wc.push_back(32'hA5A5_0000 + W'(i + 1));
            end else begin
                wd.push_back($urandom);
                wc.push_back($urandom);
            end
        end
        cycle(1'b1, 16'(len), 1'($urandom), $urandom, $urandom, mk(0, '0, '0, 1, 1, 0));
        idx = 0; stalls = 0; guard = 0;
        while (idx < total) begin
            guard++;
            case (vmode)
                0:       v = 1'b1;
                1:       v = ($urandom_range(0, 3) != 0) || (guard > 500);
                default: v = !(idx == 2 && stalls < 2);
            endcase
            st = poke_start && (idx >= N) && ($urandom_range(0, 1) == 1);
            if (v) begin
                cycle(st, 16'($urandom), 1'b1, wd[idx], wc[idx],
                      mk(idx < N, wd[idx], wc[idx], idx != total - 1, 1, 0));
                idx++;
                if (abort_at >= 0 && idx == N + abort_at + 1) begin
                    @(negedge clk);
                    #1;
                    rst = 1'b0;
                    #1;
                    check("async_reset", mk(0, '0, '0, 0, 0, 0));
                    @(posedge clk);
                    #1;
                    for (int k = 0; k < 3; k++)
                        cycle(1'b1, 16'($urandom), 1'b1, $urandom, $urandom, mk(0, '0, '0, 0, 0, 0));
                    rst = 1'b1;
                    return;
                end
            end else begin
                if (vmode == 2) stalls++;
                cycle(st, 16'($urandom), 1'b0, $urandom, $urandom, mk(0, '0, '0, 1, 1, 0));
            end
        end
        for (int k = 0; k < N; k++)
            cycle(poke_start && ($urandom_range(0, 1) == 1), 16'($urandom), 1'b1, $urandom, $urandom,
                  mk(0, '0, '0, 0, 1, k == N - 1));
    endtask

    initial begin
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEAD_BEEF;
        bus.in_coef  = 32'hCAFE_F00D;
        #3;
        check("reset_state", mk(0, '0, '0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);

        run_job(3, 0, 0, 0, -1);
        idle(2);
        run_job(3, 2, 0, 0, -1);
        idle(2);
        run_job(0, 0, 0, 0, -1);
        idle(2);
        run_job(4, 1, 0, 1, -1);
        idle(2);
        run_job(5, 0, 0, 0, 0);
        idle(2);
        run_job(1, 0, 0, 0, -1);
        idle(2);
        run_job(3, 1, 1, 0, -1);
        idle(2);
        for (int j = 0; j < 6; j++) begin
            run_job($urandom_range(0, 10), 1, 0, 1'($urandom), -1);
            idle($urandom_range(1, 3));
        end

        @(negedge clk);
        #1;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
